// File: rtl/hist_pkg.sv
// Shared constants and frame-sequencer state type for the histogram UART transmitter.
package hist_pkg;

   localparam int             HIST_NUM_BINS     = 8;
   localparam int             HIST_ADDR_W       = 3;
   localparam int             HIST_DATA_W       = 16;
   localparam logic [7:0]     HIST_SYNC_BYTE    = 8'hA5;
   localparam int             HIST_CLKS_PER_BIT = 434;

   typedef enum logic [1:0] {
      S_IDLE,
      S_HDR,
      S_PAYLOAD,
      S_FINISH
   } frame_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. ready is also high in the last stop-bit cycle so a new
// byte can be chained with no idle gap on the line.
module uart_tx_byte #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       ready
);

   localparam int             CNT_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

   tx_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shreg_q, shreg_d;
   logic             tx_q, tx_d;
   logic             bit_end;

   assign bit_end = (cnt_q == CNT_MAX);
   assign ready   = (state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_end);
   assign tx      = tx_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);
      bit_d   = bit_q;
      shreg_d = shreg_q;
      tx_d    = tx_q;
      case (state_q)
         TX_IDLE: begin
            cnt_d = '0;
            tx_d  = 1'b1;
            if (start) begin
               state_d = TX_START;
               shreg_d = data;
               tx_d    = 1'b0;
            end
         end
         TX_START: begin
            if (bit_end) begin
               state_d = TX_DATA;
               bit_d   = '0;
               tx_d    = shreg_q[0];
            end
         end
         TX_DATA: begin
            if (bit_end) begin
               if (bit_q == 3'd7) begin
                  state_d = TX_STOP;
                  tx_d    = 1'b1;
               end else begin
                  // shift so the next data bit always sits at shreg_q[1]
                  bit_d   = bit_q + 3'd1;
                  tx_d    = shreg_q[1];
                  shreg_d = {1'b0, shreg_q[7:1]};
               end
            end
         end
         TX_STOP: begin
            if (bit_end) begin
               if (start) begin
                  state_d = TX_START;
                  shreg_d = data;
                  tx_d    = 1'b0;
               end else begin
                  state_d = TX_IDLE;
               end
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= TX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
      end
   end

endmodule

// File: rtl/histogram_uart_tx.sv
// Histogram bin buffer plus frame sequencer: sends SYNC then every bin (low byte
// first) back-to-back over 8N1 UART on each accepted transmit pulse.
module histogram_uart_tx
   import hist_pkg::*;
#(
   parameter int         CLKS_PER_BIT = HIST_CLKS_PER_BIT,
   parameter int         NUM_BINS     = HIST_NUM_BINS,
   parameter int         ADDR_W       = HIST_ADDR_W,
   parameter int         DATA_W       = HIST_DATA_W,
   parameter logic [7:0] SYNC_BYTE    = HIST_SYNC_BYTE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              histogram_write_enable,
   input  logic [ADDR_W-1:0] histogram_write_address,
   input  logic [DATA_W-1:0] histogram_data,
   input  logic              histogram_transmit,
   output logic              UART_TX,
   output logic              busy,
   output logic              done
);

   localparam int             IDX_W    = ADDR_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(2 * NUM_BINS - 1);

   frame_state_e                    state_q, state_d;
   logic [IDX_W-1:0]                idx_q, idx_d;
   logic [NUM_BINS-1:0][DATA_W-1:0] bins_q, bins_d;

   logic              ser_start;
   logic              ser_ready;
   logic [7:0]        ser_data;
   logic [IDX_W-1:0]  send_idx;
   logic [DATA_W-1:0] send_word;

   assign busy = (state_q == S_HDR) || (state_q == S_PAYLOAD);
   assign done = (state_q == S_FINISH);

   // buffer is frozen for the whole frame
   always_comb begin
      bins_d = bins_q;
      if (histogram_write_enable && !busy)
         bins_d[histogram_write_address] = histogram_data;
   end

   // FINISH behaves like IDLE for acceptance so a pulse coinciding with done starts a new frame
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      ser_start = 1'b0;
      send_idx  = '0;
      case (state_q)
         S_IDLE, S_FINISH: begin
            state_d = S_IDLE;
            if (histogram_transmit) begin
               ser_start = 1'b1;
               state_d   = S_HDR;
               idx_d     = '0;
            end
         end
         S_HDR: begin
            if (ser_ready) begin
               ser_start = 1'b1;
               send_idx  = '0;
               idx_d     = '0;
               state_d   = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            if (ser_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_FINISH;
               end else begin
                  ser_start = 1'b1;
                  send_idx  = idx_q + IDX_W'(1);
                  idx_d     = send_idx;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      send_word = bins_q[send_idx[IDX_W-1:1]];
      if (state_q == S_IDLE || state_q == S_FINISH)
         ser_data = SYNC_BYTE;
      else
         ser_data = send_idx[0] ? send_word[15:8] : send_word[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         bins_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         bins_q  <= bins_d;
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .clk   (clk),
      .reset (reset),
      .start (ser_start),
      .data  (ser_data),
      .tx    (UART_TX),
      .ready (ser_ready)
   );

endmodule
